// File: rtl/if_inst_queue_pkg.sv
// ============================================================================
//  Module      : if_inst_queue_pkg
//  Description : Shared types and constants for the IF-to-ID instruction queue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef IqEntryWidth
`define IqEntryWidth 64
`endif

package if_inst_queue_pkg;

    // Both the IF and ID sides move at most this many packets per cycle.
    localparam int unsigned IQ_MAX_PORTS = 2;

    typedef logic [1:0] iq_num_t;

endpackage

`default_nettype wire

// File: rtl/if_inst_queue.sv
// ============================================================================
//  Module      : if_inst_queue
//  Description : Dual-write, dual-read circular FIFO decoupling IF from ID.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_inst_queue
    import if_inst_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = `IqEntryWidth
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     line1_in_valid_i,
    input  logic                     line2_in_valid_i,
    input  logic [ENTRY_W-1:0]       line1_in_data_i,
    input  logic [ENTRY_W-1:0]       line2_in_data_i,
    output logic                     now_allowin_o,
    output logic                     line1_out_valid_o,
    output logic                     line2_out_valid_o,
    output logic [ENTRY_W-1:0]       line1_out_data_o,
    output logic [ENTRY_W-1:0]       line2_out_data_o,
    input  logic                     next_allowin_i,
    input  logic                     next_line2_allowin_i,
    input  logic                     excep_flush_i,
    input  logic                     branch_flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_p1, rd_ptr_p1;
    logic [CNT_W-1:0]   count_q, count_d;
    iq_num_t            push_num, pop_num;
    logic               flush;

    assign flush     = excep_flush_i | branch_flush_i;
    assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
    assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

    // Admission looks only at the registered count so IF never depends on ID's ready.
    assign now_allowin_o     = (CNT_W'(DEPTH) - count_q) >= CNT_W'(IQ_MAX_PORTS);
    assign line1_out_valid_o = (count_q != '0);
    assign line2_out_valid_o = (count_q >= CNT_W'(2));
    assign line1_out_data_o  = line1_out_valid_o ? mem_q[rd_ptr_q]  : '0;
    assign line2_out_data_o  = line2_out_valid_o ? mem_q[rd_ptr_p1] : '0;
    assign count_o           = count_q;

    always_comb begin
        push_num = '0;
        if (line1_in_valid_i && now_allowin_o) begin
            push_num = line2_in_valid_i ? iq_num_t'(2) : iq_num_t'(1);
        end
    end

    always_comb begin
        pop_num = '0;
        if (line1_out_valid_o && next_allowin_i) begin
            pop_num = (line2_out_valid_o && next_line2_allowin_i) ? iq_num_t'(2) : iq_num_t'(1);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_num);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_num);
        count_d  = count_q + CNT_W'(push_num) - CNT_W'(pop_num);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!flush && (push_num != '0)) begin
            mem_q[wr_ptr_q] <= line1_in_data_i;
        end
        if (!flush && (push_num == iq_num_t'(2))) begin
            mem_q[wr_ptr_p1] <= line2_in_data_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_inst_queue.sv
// ============================================================================
//  Module      : tb_if_inst_queue
//  Description : Randomised self-checking bench for if_inst_queue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_inst_queue;

    localparam int DEPTH = 8;
    localparam int W     = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic         clk;
    logic         rst_n;
    logic         l1_in_v, l2_in_v;
    logic [W-1:0] l1_in_d, l2_in_d;
    logic         allowin;
    logic         l1_out_v, l2_out_v;
    logic [W-1:0] l1_out_d, l2_out_d;
    logic         nxt_allow, nxt_allow2;
    logic         ex_flush, br_flush;
    logic [CW-1:0] count;

    int tests_run;
    int tests_failed;

    logic [W-1:0] mq [$];

    if_inst_queue #(.DEPTH(DEPTH), .ENTRY_W(W)) u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .line1_in_valid_i     (l1_in_v),
        .line2_in_valid_i     (l2_in_v),
        .line1_in_data_i      (l1_in_d),
        .line2_in_data_i      (l2_in_d),
        .now_allowin_o        (allowin),
        .line1_out_valid_o    (l1_out_v),
        .line2_out_valid_o    (l2_out_v),
        .line1_out_data_o     (l1_out_d),
        .line2_out_data_o     (l2_out_d),
        .next_allowin_i       (nxt_allow),
        .next_line2_allowin_i (nxt_allow2),
        .excep_flush_i        (ex_flush),
        .branch_flush_i       (br_flush),
        .count_o              (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare every DUT output against the reference queue contents.
    task automatic check_state(input string tag);
        int n;
        n = mq.size();
        check_eq({tag, ".count"},   W'(count),    W'(n));
        check_eq({tag, ".allowin"}, W'(allowin),  W'((DEPTH - n) >= 2));
        check_eq({tag, ".v1"},      W'(l1_out_v), W'(n >= 1));
        check_eq({tag, ".v2"},      W'(l2_out_v), W'(n >= 2));
        check_eq({tag, ".d1"},      l1_out_d,     (n >= 1) ? mq[0] : '0);
        check_eq({tag, ".d2"},      l2_out_d,     (n >= 2) ? mq[1] : '0);
    endtask

    task automatic step(input string tag, input logic v1, input logic v2,
                        input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input logic na, input logic na2, input logic ef, input logic bf);
        int n, push, pop;
        @(negedge clk);
        l1_in_v = v1; l2_in_v = v2; l1_in_d = d1; l2_in_d = d2;
        nxt_allow = na; nxt_allow2 = na2; ex_flush = ef; br_flush = bf;
        n    = mq.size();
        push = (v1 && (DEPTH - n) >= 2) ? (v2 ? 2 : 1) : 0;
        pop  = (n >= 1 && na) ? ((n >= 2 && na2) ? 2 : 1) : 0;
        @(posedge clk);
        #1;
        if (ef || bf) begin
            mq.delete();
        end else begin
            for (int i = 0; i < pop; i++) void'(mq.pop_front());
            if (push >= 1) mq.push_back(d1);
            if (push == 2) mq.push_back(d2);
        end
        check_state(tag);
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0;
        l1_in_v = 0; l2_in_v = 0; l1_in_d = '0; l2_in_d = '0;
        nxt_allow = 0; nxt_allow2 = 0; ex_flush = 0; br_flush = 0;
        #12;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single pushes, no consumption.
        step("single0", 1, 0, 64'h1c000000, '0, 0, 0, 0, 0);
        step("single1", 1, 0, 64'h1c000004, '0, 0, 0, 0, 0);

        // Fill with a stalled ID: 2 -> 4 -> 6 -> 8, fifth push ignored.
        for (int i = 0; i < 4; i++) step("fill", 1, 1, rnd64(), rnd64(), 0, 0, 0, 0);
        step("full_ign", 1, 1, rnd64(), rnd64(), 0, 0, 0, 0);

        // Partial consume: one pop only.
        step("part_pop", 0, 0, '0, '0, 1, 0, 0, 0);

        // Flush with simultaneous push, pop and both flush sources.
        step("flush_ev", 1, 1, rnd64(), rnd64(), 1, 1, 1, 1);

        // Count 7 blocks admission even while ID pops.
        step("to1", 1, 0, rnd64(), '0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("to7", 1, 1, rnd64(), rnd64(), 0, 0, 0, 0);
        step("at7_pop", 1, 1, rnd64(), rnd64(), 1, 1, 0, 0);

        // Illegal line2-only offer and pop-from-empty.
        step("flush_ex", 0, 0, '0, '0, 0, 0, 1, 0);
        step("illegal", 0, 1, rnd64(), rnd64(), 0, 0, 0, 0);
        step("empty_pop", 0, 0, '0, '0, 1, 1, 0, 0);

        // Wrap: bring pointers to 7 then straddle the boundary.
        for (int i = 0; i < 7; i++) step("adv", 1, 0, rnd64(), '0, 1, 0, 0, 0);
        step("adv_pop", 0, 0, '0, '0, 1, 0, 0, 0);
        step("wrap_push", 1, 1, rnd64(), rnd64(), 0, 0, 0, 0);
        step("wrap_pp", 1, 1, rnd64(), rnd64(), 1, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 1), rnd64(), rnd64(),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 0));
        end

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 1, rnd64(), rnd64(), 0, 0, 0, 0);
        @(negedge clk);
        l1_in_v = 0; l2_in_v = 0; nxt_allow = 0; ex_flush = 0; br_flush = 0;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        check_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1, 1, rnd64(), rnd64(), 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
